// File: rtl/lane_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lane_arb_pkg                                               |
// | Brief   : Shared constants and state encoding for lane_rr_arbiter.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package lane_arb_pkg;

  localparam int NLANE  = 4;   // requesters / lanes
  localparam int LANE_W = 2;   // bits per lane
  localparam int SEL_W  = 2;   // log2(NLANE)
  localparam int CNT_W  = 8;   // per-lane grant counter width

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : lane_arb_pkg
`default_nettype wire

// File: rtl/lane_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lane_rr_pick                                               |
// | Brief   : Combinational round-robin winner select. Scans the         |
// |           candidate vector starting at ptr, wrapping modulo NLANE,   |
// |           and returns the first set bit (one-hot and encoded).       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module lane_rr_pick
  import lane_arb_pkg::*;
(
  input  logic [NLANE-1:0] cand,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [NLANE-1:0] onehot,
  output logic [SEL_W-1:0] idx
);

  // Rotating priority scan; SEL_W-bit addition gives the modulo wrap for free.
  always_comb begin
    logic [SEL_W-1:0] k;
    any    = 1'b0;
    onehot = '0;
    idx    = '0;
    k      = '0;
    for (int i = 0; i < NLANE; i++) begin
      k = ptr + SEL_W'(i);
      if (!any && cand[k]) begin
        any       = 1'b1;
        idx       = k;
        onehot[k] = 1'b1;
      end
    end
  end

endmodule : lane_rr_pick
`default_nettype wire

// File: rtl/lane_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lane_rr_arbiter                                            |
// | Brief   : Round-robin sequencer sharing one 2-bit lane among four    |
// |           requesters. Winner's lane is latched at grant time and     |
// |           offered downstream with valid/ready; ack pulses on the     |
// |           handshake. Back-to-back grants skip the current owner.     |
// | Options : LANE_ARB_STATS_EN adds grant_cnt, one 8-bit saturating     |
// |           handshake counter per lane.                                |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module lane_rr_arbiter
  import lane_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NLANE-1:0]        req,
  input  logic [NLANE*LANE_W-1:0] data_in,
  output logic [NLANE-1:0]        ack,
  output logic [NLANE-1:0]        grant,
  output logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  output logic [LANE_W-1:0]       out_data,
  input  logic                    out_ready
`ifdef LANE_ARB_STATS_EN
  ,
  output logic [NLANE*CNT_W-1:0]  grant_cnt
`endif
);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [NLANE-1:0]    grant_q, grant_d;
  logic                valid_q, valid_d;
  logic [LANE_W-1:0]   data_q, data_d;

  logic                hs;
  logic [NLANE-1:0]    pick_cand;
  logic [SEL_W-1:0]    pick_ptr;
  logic                win_any;
  logic [NLANE-1:0]    win_oh;
  logic [SEL_W-1:0]    win_idx;
  logic [LANE_W-1:0]   win_data;

  // Handshake and same-cycle acceptance pulse to the current owner.
  always_comb begin
    hs  = (state_q == GRANT) && valid_q && out_ready;
    ack = hs ? grant_q : '0;
  end

  // From IDLE all requesters compete at the stored pointer; from GRANT the
  // owner is excluded and the pointer advances past it, so a re-grant
  // needs no extra cycle to update ptr first.
  always_comb begin
    if (state_q == IDLE) begin
      pick_cand = req;
      pick_ptr  = ptr_q;
    end else begin
      pick_cand = req & ~grant_q;
      pick_ptr  = sel_q + SEL_W'(1);
    end
  end

  lane_rr_pick u_pick (
    .cand   (pick_cand),
    .ptr    (pick_ptr),
    .any    (win_any),
    .onehot (win_oh),
    .idx    (win_idx)
  );

  assign win_data = data_in[int'(win_idx)*LANE_W +: LANE_W];

  // Next-state and register-load decisions.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (win_any) begin
          sel_d   = win_idx;
          grant_d = win_oh;
          data_d  = win_data;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (hs) begin
          ptr_d = sel_q + SEL_W'(1);
          if (win_any) begin
            sel_d   = win_idx;
            grant_d = win_oh;
            data_d  = win_data;
            valid_d = 1'b1;
          end else begin
            grant_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

`ifdef LANE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NLANE];

  for (genvar g = 0; g < NLANE; g++) begin : g_cnt
    // Saturating per-lane handshake counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[g] <= '0;
      end else if (ack[g] && (cnt_q[g] != {CNT_W{1'b1}})) begin
        cnt_q[g] <= cnt_q[g] + CNT_W'(1);
      end
    end
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule : lane_rr_arbiter
`default_nettype wire

// File: tb/tb_lane_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_lane_rr_arbiter                                         |
// | Brief   : Scoreboard bench for lane_rr_arbiter. A transaction-level  |
// |           model pushes each expected grant when it is decided; a     |
// |           negedge monitor checks outputs and pops on handshake.      |
// |           Build with LANE_ARB_STATS_EN to also check grant_cnt.      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_lane_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  data_in;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        out_valid;
  logic [1:0]  out_data;
  logic        out_ready;
`ifdef LANE_ARB_STATS_EN
  logic [31:0] grant_cnt;
`endif

  lane_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .ack       (ack),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef LANE_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the lane, which lane starts the next scan,
  // and the queue of granted-but-not-yet-accepted transfers.
  typedef struct { int lane; int data; } txn_t;
  txn_t sb[$];
  bit   m_busy;
  int   m_owner;
  int   m_ptr;
  int   m_cnt [4];
  bit   mon_en = 1'b0;

  function automatic int rr_pick(input logic [3:0] c, input int p);
    for (int i = 0; i < 4; i++)
      if (c[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic grant_to(input int w);
    txn_t t;
    t.lane  = w;
    t.data  = int'((data_in >> (2 * w)) & 8'd3);
    m_busy  = 1'b1;
    m_owner = w;
    sb.push_back(t);
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    logic [3:0] cand;
    if (m_busy) begin
      if (out_ready) begin
        if (m_cnt[m_owner] < 255) m_cnt[m_owner]++;
        m_ptr = (m_owner + 1) % 4;
        cand  = req & ~(4'b0001 << m_owner);
        if (cand != 4'b0000) grant_to(rr_pick(cand, m_ptr));
        else m_busy = 1'b0;
      end
    end else if (req != 4'b0000) begin
      grant_to(rr_pick(req, m_ptr));
    end
  endtask

  task automatic model_clear();
    m_busy = 1'b0;
    m_owner = 0;
    m_ptr = 0;
    sb.delete();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_sel",   32'(sel), 32'd0);
    check("rst_data",  32'(out_data), 32'd0);
    check("rst_ack",   32'(ack), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare every cycle against the model, pop on handshake.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("mon_valid", 32'(out_valid), 32'(m_busy));
      if (m_busy) begin
        if (sb.size() == 0) begin
          check("mon_sb_empty", 32'd1, 32'd0);
        end else begin
          check("mon_sel",   32'(sel), 32'(sb[0].lane));
          check("mon_data",  32'(out_data), 32'(sb[0].data));
          check("mon_grant", 32'(grant), 32'(4'b0001 << sb[0].lane));
          check("mon_ack",   32'(ack), out_ready ? 32'(4'b0001 << sb[0].lane) : 32'd0);
          if (out_valid && out_ready) void'(sb.pop_front());
        end
      end else begin
        check("mon_idle_grant", 32'(grant), 32'd0);
        check("mon_idle_ack",   32'(ack), 32'd0);
      end
    end
  end

  int exp_sel [5] = '{0, 1, 2, 3, 0};
  int exp_dat [5] = '{3, 1, 2, 1, 3};

  initial begin
    req = '0; data_in = '0; out_ready = 1'b0; rst_n = 1'b0;
    do_reset();
    mon_en = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      step();
      #3;
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_grant", 32'(grant), 32'd0);
    end

    // Single requester, lane 0.
    data_in = 8'b01100111; req = 4'b0001; out_ready = 1'b1;
    step(); #3;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_sel",   32'(sel), 32'd0);
    check("single_data",  32'(out_data), 32'd3);
    check("single_ack",   32'(ack), 32'd1);
    req = 4'b0000;
    step(); #3;
    check("single_idle",  32'(out_valid), 32'd0);
    check("single_ack0",  32'(ack), 32'd0);

    // All four requesting: back-to-back rotation with 3->0 wrap.
    do_reset();
    data_in = 8'b01100111; req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); #3;
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_sel",   32'(sel), 32'(exp_sel[i]));
      check("rr_data",  32'(out_data), 32'(exp_dat[i]));
      check("rr_ack",   32'(ack), 32'(4'b0001 << exp_sel[i]));
    end
    req = 4'b0000;
    repeat (3) step();

    // Downstream stall: hold lane 2 while data_in changes.
    do_reset();
    data_in = 8'b01100111; req = 4'b0100; out_ready = 1'b0;
    step();
    data_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step(); #3;
      check("hold_data", 32'(out_data), 32'd2);
      check("hold_sel",  32'(sel), 32'd2);
      check("hold_ack",  32'(ack), 32'd0);
    end
    out_ready = 1'b1; #1;
    check("hold_release_ack", 32'(ack), 32'b0100);
    step();
    req = 4'b0000;
    repeat (2) step();

    // Asynchronous reset in the middle of a grant.
    do_reset();
    data_in = 8'b01100111; req = 4'b0010; out_ready = 1'b0;
    repeat (2) step();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_sel",   32'(sel), 32'd0);
    check("arst_data",  32'(out_data), 32'd0);
    check("arst_ack",   32'(ack), 32'd0);
    model_clear();
    req = 4'b1000;
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(); #3;
    check("arst_regrant", 32'(grant), 32'b1000);
    req = 4'b0000; out_ready = 1'b1;
    repeat (3) step();

    // Randomized traffic with one mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 0) req = 4'($urandom_range(0, 15));
      data_in   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (i == 800) do_reset();
      step();
    end

`ifdef LANE_ARB_STATS_EN
    // Saturating counters: well over 255 handshakes on lane 1.
    do_reset();
    req = 4'b0010; out_ready = 1'b1;
    repeat (620) step();
    #3;
    for (int i = 0; i < 4; i++)
      check("cnt_model", 32'(grant_cnt[i*8 +: 8]), 32'(m_cnt[i]));
    check("cnt_lane1_sat", 32'(grant_cnt[15:8]), 32'd255);
    check("cnt_others", 32'({grant_cnt[31:16], grant_cnt[7:0]}), 32'd0);
    req = 4'b0000;
    repeat (2) step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_lane_rr_arbiter
`default_nettype wire

// File: doc/lane_rr_arbiter.md
Name: lane_rr_arbiter

Overview:
- Shares one 2-bit output lane among four requesters. Each requester presents a 2-bit field packed into an 8-bit bus.
- Round-robin arbitration picks one requester and drives the lane select. The selected field is latched and offered downstream with a valid/ready handshake.
- Sits in front of the 4:1 lane-select datapath as its sequencer.

Parameters:
- NLANE, 4, number of requesters/lanes (fixed at 4 for this revision)
- LANE_W, 2, bits per lane
- SEL_W, 2, select width, log2(NLANE)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  NLANE  per-requester request, level
- data_in  input  NLANE*LANE_W  packed lanes; lane i = data_in[LANE_W*i +: LANE_W]
- ack  output  NLANE  one-hot acceptance pulse to the served requester
- grant  output  NLANE  one-hot current owner, registered
- sel  output  SEL_W  encoded current owner, registered
- out_valid  output  1  downstream valid
- out_data  output  LANE_W  latched lane data
- out_ready  input  1  downstream ready

Behaviour:
- Reset (async assert, sync deassert by the system):
  - grant=0, sel=0, out_valid=0, out_data=0, ack=0.
  - Priority pointer ptr=0; state=IDLE.
- Reset mid-transaction drops the transaction silently; no ack is issued.
- Winner function: first set bit of the candidate vector, scanning ptr, ptr+1, ... modulo NLANE.
- State IDLE:
  - out_valid=0.
  - If |req at the clock edge: winner w is taken from req. Registers load sel<=w, grant<=1<<w, out_data<=data_in lane w, out_valid<=1. Go to GRANT.
  - Latency: req sampled at edge N gives out_valid high after edge N.
- State GRANT:
  - out_valid=1; out_data, sel and grant are held stable until handshake.
  - Handshake is out_valid & out_ready. ack = grant when the handshake occurs, else 0 (combinational, same cycle).
  - On handshake, ptr<=sel+1 (wraps 3->0 by SEL_W truncation).
  - Next candidates = req & ~grant, using the new ptr. If non-zero, load the next winner directly and stay in GRANT (back-to-back, no bubble). Else go to IDLE with out_valid<=0, grant<=0, sel holding its last value.
- Data is captured at grant time. The requester may change data_in or drop req after grant without affecting out_data.
- Dropping req while granted does not cancel the transaction; ack still pulses at handshake.
- Requesters must deassert req the cycle after ack, or they re-enter arbitration with the lowest priority.
- out_ready held low: GRANT is held indefinitely with all outputs stable, and ptr is unchanged.
- Single requester continuously asserting: it is served every handshake after the idle gap. Current owner is excluded from the back-to-back pick, so it returns via IDLE (one bubble).
- Fairness: no requester waits more than NLANE-1 grants while continuously requesting.

Optional Feature:
- Macro LANE_ARB_STATS_EN.
- Defined: adds output port grant_cnt (NLANE*8 bits), one 8-bit saturating counter per lane.
  - The counter increments on each handshake for that lane and saturates at 255.
  - Cleared by rst_n.
- Undefined: port and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package lane_arb_pkg holds NLANE, LANE_W, SEL_W constants and the state encoding (IDLE=1'b0, GRANT=1'b1).
- One sub-module, lane_rr_pick: combinational, takes candidate vector and ptr, outputs any-valid, one-hot winner and encoded index.
- The lane extraction is an indexed part-select inline in the top; no separate mux module.

Test Plan:
- Reset, then req=4'b0000 for 10 cycles -> out_valid=0, grant=0, ack=0 throughout.
- data_in=8'b01100111, req=4'b0001, out_ready=1 -> out_valid after 1 edge; sel=0, out_data=2'b11, ack=4'b0001 for one cycle; return to IDLE.
- data_in=8'b01100111, req=4'b1111 held, out_ready=1 -> sel sequence 0,1,2,3,0 with out_data 11,01,10,01,11.
  - Back-to-back with no bubble between owners; confirms the 3->0 wrap.
- req=4'b0100, out_ready=0 for 5 cycles, change data_in to 8'h00 -> out_data stays 2'b10, sel=2, no ack. Then out_ready=1 gives ack=4'b0100.
- Mid-GRANT with out_valid=1, assert rst_n=0 asynchronously -> outputs clear immediately without waiting for clk. After release with req=4'b1000, grant=4'b1000 (ptr reset to 0).
- With LANE_ARB_STATS_EN: 300 handshakes on lane 1 -> grant_cnt lane 1 = 255, other lanes 0.
